// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence-detector chain. It takes
// WIDTH-bit words over valid/ready and emits one bit per enabled clock.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] sh_data;
  logic [WIDTH-1:0] sh_shifted;
  logic [WIDTH-1:0] hold_data;
  logic [CW-1:0]    sh_cnt;
  logic             hold_full;

  logic accept;
  logic advance;
  logic last;
  logic empty_slot;
  logic load_hold;
  logic load_bypass;
  logic head;

  assign ser_valid   = (sh_cnt != '0);
  assign head        = MSB_FIRST ? sh_data[WIDTH-1] : sh_data[0];
  assign ser_bit     = ser_valid ? head : IDLE_BIT;
  assign word_done   = ser_valid && (sh_cnt == ONE_CNT);
  assign busy        = ser_valid || hold_full;

  assign in_ready    = !reset && !hold_full;
  assign accept      = in_valid && in_ready;
  assign advance     = bit_en && ser_valid;
  assign last        = advance && (sh_cnt == ONE_CNT);
  assign empty_slot  = !ser_valid || last;
  assign load_hold   = empty_slot && hold_full;
  assign load_bypass = empty_slot && !hold_full && accept;

  // Remaining bits move one position toward the head bit.
  always_comb begin
    sh_shifted = sh_data;
    if (MSB_FIRST) begin
      sh_shifted = {sh_data[WIDTH-2:0], 1'b0};
    end else begin
      sh_shifted = {1'b0, sh_data[WIDTH-1:1]};
    end
  end

  // An empty shifter loads regardless of bit_en so back-to-back words stay gap-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_data   <= '0;
      sh_cnt    <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      if (load_hold) begin
        sh_data <= hold_data;
        sh_cnt  <= FULL_CNT;
      end else if (load_bypass) begin
        sh_data <= in_data;
        sh_cnt  <= FULL_CNT;
      end else if (advance) begin
        sh_data <= sh_shifted;
        sh_cnt  <= sh_cnt - ONE_CNT;
      end

      if (load_hold) begin
        if (accept) begin
          hold_data <= in_data;
        end else begin
          hold_full <= 1'b0;
        end
      end else if (accept && !load_bypass) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule
